// File: rtl/xike_cfg_pkg.sv
// Shared constants for the threshold-table config loader: opcodes, header layout, FSM states.
package xike_cfg_pkg;

  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_READ  = 4'h2;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 28;
  localparam int CNT_MSB  = 27;
  localparam int CNT_LSB  = 16;
  localparam int BASE_MSB = 15;
  localparam int BASE_LSB = 0;

  localparam int DEF_DEPTH    = 256;
  localparam int DEF_BANK_NUM = 5;
  localparam int ADDR_LIMIT   = DEF_BANK_NUM * DEF_DEPTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RD_OUT,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/thres_cfg_loader.sv
// Host command decoder driving the threshold table BRAM port and a readback stream.
// Optional CFG_CHECKSUM_EN: WRITE commands carry a trailing XOR-of-payload word.
module thres_cfg_loader
  import xike_cfg_pkg::*;
#(
  parameter int BITWIDTH = 32,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int BANK_NUM = DEF_BANK_NUM
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BITWIDTH-1:0] cmd_data,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  output logic [15:0]         bram_addr,
  output logic [BITWIDTH-1:0] bram_din,
  output logic                bram_we,
  output logic                bram_re,
  input  logic [BITWIDTH-1:0] bram_dout,
  output logic [BITWIDTH-1:0] rd_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic                busy,
  output logic                done,
  output logic                err,
  input  logic                err_clr
);

  localparam logic [16:0] ADDR_LIM = 17'(BANK_NUM * DEPTH);
`ifdef CFG_CHECKSUM_EN
  localparam logic [12:0] TRL_WORDS = 13'd1;
`else
  localparam logic [12:0] TRL_WORDS = 13'd0;
`endif

  state_t                state_r, state_n;
  logic [15:0]           cur_r, cur_n;
  logic [12:0]           rem_r, rem_n;
  logic                  cmd_ready_r, cmd_ready_n;
  logic [15:0]           addr_r, addr_n;
  logic [BITWIDTH-1:0]   din_r, din_n;
  logic                  we_r, we_n, re_r, re_n;
  logic [BITWIDTH-1:0]   rd_data_r, rd_data_n;
  logic                  rd_valid_r, rd_valid_n;
  logic                  done_r, done_n;
  logic                  err_r, err_n, err_set_s;
  logic [3:0]            hdr_op_s;
  logic [11:0]           hdr_cnt_s;
  logic [15:0]           hdr_base_s;
  logic [16:0]           hdr_end_s;
  logic                  oor_s, accept_s, last_s, trailer_s;
`ifdef CFG_CHECKSUM_EN
  logic [BITWIDTH-1:0]   csum_r, csum_n;
`endif

  assign hdr_op_s   = cmd_data[OP_MSB:OP_LSB];
  assign hdr_cnt_s  = cmd_data[CNT_MSB:CNT_LSB];
  assign hdr_base_s = cmd_data[BASE_MSB:BASE_LSB];
  // 17-bit end address so base near 0xFFFF plus a large count cannot wrap into range
  assign hdr_end_s  = {1'b0, hdr_base_s} + {5'd0, hdr_cnt_s} + 17'd1;
  assign oor_s      = (hdr_end_s > ADDR_LIM);
  assign accept_s   = cmd_valid & cmd_ready_r;
  assign last_s     = (rem_r == 13'd0);
`ifdef CFG_CHECKSUM_EN
  assign trailer_s  = (rem_r == 13'd0);
`else
  assign trailer_s  = 1'b0;
`endif

  // Next-state, counters and registered-output values
  always_comb begin
    state_n    = state_r;
    cur_n      = cur_r;
    rem_n      = rem_r;
    addr_n     = addr_r;
    din_n      = din_r;
    we_n       = 1'b0;
    re_n       = 1'b0;
    rd_data_n  = rd_data_r;
    rd_valid_n = rd_valid_r;
    done_n     = 1'b0;
    err_set_s  = 1'b0;
`ifdef CFG_CHECKSUM_EN
    csum_n     = csum_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (hdr_op_s)
            OP_WRITE: begin
              cur_n = hdr_base_s;
              rem_n = {1'b0, hdr_cnt_s} + TRL_WORDS;
`ifdef CFG_CHECKSUM_EN
              csum_n = {BITWIDTH{1'b0}};
`endif
              if (oor_s) begin
                err_set_s = 1'b1;
                state_n   = ST_DRAIN;
              end else begin
                state_n   = ST_WRITE;
              end
            end
            OP_READ: begin
              if (oor_s) begin
                err_set_s = 1'b1;
                done_n    = 1'b1;
              end else begin
                cur_n   = hdr_base_s;
                rem_n   = {1'b0, hdr_cnt_s};
                addr_n  = hdr_base_s;
                re_n    = 1'b1;
                state_n = ST_RD_REQ;
              end
            end
            default: begin
              err_set_s = 1'b1;
              done_n    = 1'b1;
            end
          endcase
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (accept_s && trailer_s) begin
`ifdef CFG_CHECKSUM_EN
          err_set_s = (cmd_data != csum_r);
`endif
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end else if (accept_s) begin
          we_n  = 1'b1;
          addr_n = cur_r;
          din_n = cmd_data;
          cur_n = cur_r + 16'd1;
`ifdef CFG_CHECKSUM_EN
          csum_n = csum_r ^ cmd_data;
`endif
          if (last_s) begin
            done_n  = 1'b1;
            state_n = ST_IDLE;
          end else begin
            rem_n = rem_r - 13'd1;
          end
        end else begin
          state_n = ST_WRITE;
        end
      end
      ST_RD_REQ:  state_n = ST_RD_WAIT;
      ST_RD_WAIT: begin
        rd_data_n  = bram_dout;
        rd_valid_n = 1'b1;
        state_n    = ST_RD_OUT;
      end
      ST_RD_OUT: begin
        if (rd_ready) begin
          rd_valid_n = 1'b0;
          if (last_s) begin
            done_n  = 1'b1;
            state_n = ST_IDLE;
          end else begin
            cur_n   = cur_r + 16'd1;
            rem_n   = rem_r - 13'd1;
            addr_n  = cur_r + 16'd1;
            re_n    = 1'b1;
            state_n = ST_RD_REQ;
          end
        end else begin
          state_n = ST_RD_OUT;
        end
      end
      ST_DRAIN: begin
        if (accept_s && last_s) begin
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end else if (accept_s) begin
          rem_n = rem_r - 13'd1;
        end else begin
          state_n = ST_DRAIN;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    cmd_ready_n = (state_n == ST_IDLE) || (state_n == ST_WRITE) || (state_n == ST_DRAIN);
    err_n       = err_set_s ? 1'b1 : (err_clr ? 1'b0 : err_r);
  end

  // State, counters and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cur_r       <= 16'd0;
      rem_r       <= 13'd0;
      cmd_ready_r <= 1'b0;
      addr_r      <= 16'd0;
      din_r       <= {BITWIDTH{1'b0}};
      we_r        <= 1'b0;
      re_r        <= 1'b0;
      rd_data_r   <= {BITWIDTH{1'b0}};
      rd_valid_r  <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
`ifdef CFG_CHECKSUM_EN
      csum_r      <= {BITWIDTH{1'b0}};
`endif
    end else begin
      state_r     <= state_n;
      cur_r       <= cur_n;
      rem_r       <= rem_n;
      cmd_ready_r <= cmd_ready_n;
      addr_r      <= addr_n;
      din_r       <= din_n;
      we_r        <= we_n;
      re_r        <= re_n;
      rd_data_r   <= rd_data_n;
      rd_valid_r  <= rd_valid_n;
      done_r      <= done_n;
      err_r       <= err_n;
`ifdef CFG_CHECKSUM_EN
      csum_r      <= csum_n;
`endif
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign bram_addr = addr_r;
  assign bram_din  = din_r;
  assign bram_we   = we_r;
  assign bram_re   = re_r;
  assign rd_data   = rd_data_r;
  assign rd_valid  = rd_valid_r;
  assign done      = done_r;
  assign err       = err_r;
  assign busy      = (state_r != ST_IDLE);

endmodule

// File: doc/thres_cfg_loader.md
Name: thres_cfg_loader

Overview:
- Host-side writer for the per-channel threshold/hash/offset/group/reference table BRAM.
- Receives a 32-bit command word stream from the host link FIFO. Each command is one header word plus payload.
- Decodes write and readback commands and drives the table's addr/din/we/re port.
- Returns readback words on an output stream with valid/ready backpressure.

Parameters:
- BITWIDTH, 32, data word width (equal to table word width)
- DEPTH, 256, entries per table bank
- BANK_NUM, 5, number of banks; addressable range is 0 .. BANK_NUM*DEPTH-1 (default 0..1279)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cmd_data  in  BITWIDTH  host command/payload word
- cmd_valid  in  1  cmd_data valid
- cmd_ready  out  1  loader accepts cmd_data this cycle
- bram_addr  out  16  table address
- bram_din  out  BITWIDTH  table write data
- bram_we  out  1  table write strobe
- bram_re  out  1  table read strobe
- bram_dout  in  BITWIDTH  table read data, valid 1 cycle after bram_re
- rd_data  out  BITWIDTH  readback word
- rd_valid  out  1  readback word valid
- rd_ready  in  1  consumer accepts readback word
- busy  out  1  command in progress (state != IDLE)
- done  out  1  one-cycle pulse at command completion
- err  out  1  sticky error flag
- err_clr  in  1  clears err

Behaviour:
- Reset values: all outputs 0 (cmd_ready, bram_*, rd_*, busy, done, err); state IDLE; internal addr/count 0. The async assert takes effect immediately; a reset mid-command abandons it with no further we/re.
- Header word fields: [31:28] opcode (4'h1 WRITE, 4'h2 READ), [27:16] count-1 (1..4096 words), [15:0] base address.
- Range rule: base + count > BANK_NUM*DEPTH is a range error.
  - Compute the check in 17 bits so there is no wrap.
  - Exact fill of the last address is legal.
- States: IDLE, WRITE, RD_REQ, RD_WAIT, RD_OUT, DRAIN.
- IDLE:
  - cmd_ready=1; a header is accepted on cmd_valid.
  - WRITE opcode, in range -> WRITE.
  - WRITE opcode, out of range -> set err, DRAIN (consumes count payload words, no bram_we).
  - READ opcode, in range -> RD_REQ.
  - READ opcode, out of range -> set err, pulse done, IDLE.
  - Unknown opcode -> set err, pulse done, IDLE (header only consumed).
- WRITE:
  - cmd_ready=1. On each accepted word, the next cycle has bram_we=1, bram_addr=cur, bram_din=word. Then cur+1 and remaining-1.
  - After the last word: done pulse, IDLE.
  - Throughput is 1 word/cycle. Gaps in cmd_valid are allowed, and bram_we=0 during gaps.
- RD_REQ: bram_re=1 and bram_addr=cur for one cycle -> RD_WAIT.
- RD_WAIT: capture bram_dout into rd_data, rd_valid=1 -> RD_OUT.
- RD_OUT:
  - Hold rd_data and rd_valid until rd_ready.
  - On handshake: rd_valid=0; if remaining>0, then cur+1 -> RD_REQ; else done pulse -> IDLE.
  - cmd_ready=0 throughout a read.
- DRAIN: cmd_ready=1; discard words until count is consumed; done pulse -> IDLE.
- bram_we and bram_re are never both high. Each is high for at most one cycle per word.
- Strobes and bram_addr/bram_din are registered outputs.
- err is sticky. err_clr clears it. If err_clr and a new error occur in the same cycle, err stays 1.
- busy = (state != IDLE).

Optional Feature:
- Macro: CFG_CHECKSUM_EN.
- When defined:
  - A WRITE command carries one extra trailing word after the payload: the XOR of all payload words.
  - Payload writes proceed as normal.
  - On a trailer mismatch, set err and also pulse done.
  - DRAIN also consumes the trailer.
- When undefined: no trailer word; the checksum logic is absent.

Decomposition:
- Package xike_cfg_pkg holds:
  - opcode constants OP_WRITE/OP_READ
  - header field bit positions
  - state enum
  - ADDR_LIMIT = BANK_NUM*DEPTH
- No sub-module: a single FSM plus address/count registers.

Test Plan:
- Write: header 0x1002_0100 then 3 words A,B,C -> we at addr 256,257,258 with A,B,C; done pulse once; err=0.
- Read with backpressure: after the write, header 0x2002_0100, rd_ready low 5 cycles -> rd_valid held; words A,B,C out in order; exactly one re per word.
- Range: header 0x1001_04FF (base 1279, count 2) -> err=1, 2 payload words drained, no we. Header 0x1000_04FF -> single write at 1279 accepted.
- Unknown opcode 0x7000_0000 -> err=1, IDLE next cycle. err_clr -> err=0.
- Reset asserted mid-WRITE after 1 of 4 words -> all outputs 0 immediately; a following clean command executes correctly.
- With CFG_CHECKSUM_EN: payload 0x5,0x3 with trailer 0x6 -> err=0. With trailer 0x7 -> err=1, both writes present.
